// File: rtl/tcc_pkg.sv
// Shared types and constants for the up-transition counter sequencer.
`default_nettype none

package tcc_pkg;

  localparam int COUNT_W        = 4;
  localparam int LEVEL_MAX_DEF  = 15;
  localparam int HOLD_TICKS_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_UP     = 3'd2,
    ST_SETTLE = 3'd3,
    ST_HOLD   = 3'd4,
    ST_ACK    = 3'd5
  } tcc_state_e;

endpackage

`default_nettype wire

// File: rtl/transition_counter_ctrl_if.sv
// Request/strobe bundle between game logic, the sequencer and the level counter.
`default_nettype none

interface transition_counter_ctrl_if;
  import tcc_pkg::*;

  logic               level_req_i;
  logic               restart_req_i;
  logic               tick_i;
  logic [COUNT_W-1:0] count_i;
  logic               upcount_InLow_o;
  logic               clear_InLow_o;
  logic               busy_o;
  logic               ack_o;
  logic               transition_active_o;
  logic               max_level_o;

  modport slave (
    input  level_req_i, restart_req_i, tick_i, count_i,
    output upcount_InLow_o, clear_InLow_o, busy_o, ack_o,
           transition_active_o, max_level_o
  );

  modport master (
    output level_req_i, restart_req_i, tick_i, count_i,
    input  upcount_InLow_o, clear_InLow_o, busy_o, ack_o,
           transition_active_o, max_level_o
  );

endinterface

`default_nettype wire

// File: rtl/tcc_hold_timer.sv
// Frame-tick counter for the transition window; o_done fires on the last tick.
`default_nettype none

module tcc_hold_timer #(
  parameter int HOLD_TICKS = 4
) (
  input  wire logic SC_upTRANSITIONCOUNTER_CLOCK_50,
  input  wire logic SC_upTRANSITIONCOUNTER_RESET_InHigh,
  input  wire logic i_load,
  input  wire logic i_tick,
  output logic      o_done
);

  localparam int c_cnt_w = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [c_cnt_w-1:0] c_term =
    (HOLD_TICKS > 0) ? c_cnt_w'(HOLD_TICKS - 1) : '0;

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge SC_upTRANSITIONCOUNTER_CLOCK_50 or posedge SC_upTRANSITIONCOUNTER_RESET_InHigh) begin
    if (SC_upTRANSITIONCOUNTER_RESET_InHigh) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_done = i_tick && (r_cnt == c_term);

endmodule

`default_nettype wire

// File: rtl/transition_counter_ctrl.sv
// Arbitrates restart/level requests into one-cycle active-low counter strobes.
// Optional transition window enabled by `define TRANSITION_HOLD_EN.
`default_nettype none

module transition_counter_ctrl
  import tcc_pkg::*;
#(
  parameter int LEVEL_MAX  = LEVEL_MAX_DEF,
  parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
  input  wire logic                SC_upTRANSITIONCOUNTER_CLOCK_50,
  input  wire logic                SC_upTRANSITIONCOUNTER_RESET_InHigh,
  transition_counter_ctrl_if.slave bus
);

  localparam logic [COUNT_W-1:0] c_level_max = COUNT_W'(LEVEL_MAX);

  tcc_state_e r_state;
  logic       r_upcount_n;
  logic       r_clear_n;
  logic       r_busy;
  logic       r_ack;
  logic       r_max_level;
  logic       r_arm_restart;
  logic       r_arm_level;
  logic       r_svc_restart;
  logic       w_hold_done;

`ifdef TRANSITION_HOLD_EN
  logic r_trans_active;

  tcc_hold_timer #(
    .HOLD_TICKS (HOLD_TICKS)
  ) u_hold_timer (
    .SC_upTRANSITIONCOUNTER_CLOCK_50     (SC_upTRANSITIONCOUNTER_CLOCK_50),
    .SC_upTRANSITIONCOUNTER_RESET_InHigh (SC_upTRANSITIONCOUNTER_RESET_InHigh),
    .i_load                              (r_state == ST_SETTLE),
    .i_tick                              ((r_state == ST_HOLD) && bus.tick_i),
    .o_done                              (w_hold_done)
  );

  assign bus.transition_active_o = r_trans_active;
`else
  wire w_unused_tick = &{1'b0, bus.tick_i};

  assign w_hold_done             = 1'b0;
  assign bus.transition_active_o = 1'b0;
`endif

  always_ff @(posedge SC_upTRANSITIONCOUNTER_CLOCK_50 or posedge SC_upTRANSITIONCOUNTER_RESET_InHigh) begin
    if (SC_upTRANSITIONCOUNTER_RESET_InHigh) begin
      r_state       <= ST_IDLE;
      r_upcount_n   <= 1'b1;
      r_clear_n     <= 1'b1;
      r_busy        <= 1'b0;
      r_ack         <= 1'b0;
      r_max_level   <= 1'b0;
      r_arm_restart <= 1'b1;
      r_arm_level   <= 1'b1;
      r_svc_restart <= 1'b0;
`ifdef TRANSITION_HOLD_EN
      r_trans_active <= 1'b0;
`endif
    end else begin
      r_upcount_n <= 1'b1;
      r_clear_n   <= 1'b1;
      r_ack       <= 1'b0;

      // A requester re-arms only after being seen low; the ACK branch below overrides.
      if (!bus.restart_req_i) r_arm_restart <= 1'b1;
      if (!bus.level_req_i)   r_arm_level   <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (bus.restart_req_i && r_arm_restart) begin
            r_state       <= ST_CLEAR;
            r_clear_n     <= 1'b0;
            r_busy        <= 1'b1;
            r_svc_restart <= 1'b1;
          end else if (bus.level_req_i && r_arm_level) begin
            r_busy        <= 1'b1;
            r_svc_restart <= 1'b0;
            if (bus.count_i == c_level_max) begin
              r_max_level <= 1'b1;
              r_state     <= ST_ACK;
              r_ack       <= 1'b1;
            end else begin
              r_state     <= ST_UP;
              r_upcount_n <= 1'b0;
            end
          end
        end

        ST_CLEAR: begin
          r_max_level <= 1'b0;
          r_state     <= ST_SETTLE;
        end

        ST_UP: begin
          r_state <= ST_SETTLE;
        end

        ST_SETTLE: begin
`ifdef TRANSITION_HOLD_EN
          if (HOLD_TICKS > 0) begin
            r_state        <= ST_HOLD;
            r_trans_active <= 1'b1;
          end else begin
            r_state <= ST_ACK;
            r_ack   <= 1'b1;
          end
`else
          r_state <= ST_ACK;
          r_ack   <= 1'b1;
`endif
        end

`ifdef TRANSITION_HOLD_EN
        ST_HOLD: begin
          if (w_hold_done) begin
            r_trans_active <= 1'b0;
            r_state        <= ST_ACK;
            r_ack          <= 1'b1;
          end
        end
`endif

        ST_ACK: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          if (r_svc_restart) r_arm_restart <= 1'b0;
          else               r_arm_level   <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
`ifdef TRANSITION_HOLD_EN
          r_trans_active <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign bus.upcount_InLow_o = r_upcount_n;
  assign bus.clear_InLow_o   = r_clear_n;
  assign bus.busy_o          = r_busy;
  assign bus.ack_o           = r_ack;
  assign bus.max_level_o     = r_max_level;

endmodule

`default_nettype wire

// File: tb/tb_transition_counter_ctrl.sv
// Directed bench: table of single transactions against a behavioural 4-bit counter.
`default_nettype none

module tb_transition_counter_ctrl;
  import tcc_pkg::*;

  localparam int HT = 4;
`ifdef TRANSITION_HOLD_EN
  localparam int EX = HT;
`else
  localparam int EX = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  transition_counter_ctrl_if bus();

  transition_counter_ctrl #(
    .LEVEL_MAX  (15),
    .HOLD_TICKS (HT)
  ) dut (
    .SC_upTRANSITIONCOUNTER_CLOCK_50     (clk),
    .SC_upTRANSITIONCOUNTER_RESET_InHigh (rst),
    .bus                                 (bus)
  );

  // Behavioural level counter driven by the strobes; the bench can preload it.
  logic       tb_load = 1'b0;
  logic [3:0] tb_val  = 4'd0;
  logic [3:0] cnt_m;
  logic       tick_en = 1'b1;

  always @(posedge clk) begin
    if (tb_load)                   cnt_m <= tb_val;
    else if (!bus.clear_InLow_o)   cnt_m <= 4'd0;
    else if (!bus.upcount_InLow_o) cnt_m <= cnt_m + 4'd1;
  end

  assign bus.count_i = cnt_m;
  assign bus.tick_i  = tick_en;

  int n_up = 0, n_clr = 0, n_ta = 0, n_ack = 0, n_both = 0;
  always @(negedge clk) begin
    if (!bus.upcount_InLow_o) n_up++;
    if (!bus.clear_InLow_o) n_clr++;
    if (bus.transition_active_o) n_ta++;
    if (bus.ack_o) n_ack++;
    if (!bus.upcount_InLow_o && !bus.clear_InLow_o) n_both++;
  end

  int nvec = 0, nfail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_ack(output int k);
    k = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (bus.ack_o) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic preload(input logic [3:0] v);
    @(negedge clk);
    tb_load = 1'b1;
    tb_val  = v;
    @(negedge clk);
    tb_load = 1'b0;
  endtask

  typedef struct {
    logic       rs;
    logic       lv;
    logic [3:0] cnt0;
    logic [3:0] cnt1;
    logic       maxl;
    int         ups;
    int         clrs;
    bit         strobe;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int k, k2, u0, c0, t0, a0;
    string nm;

    vecs[0] = '{1'b0, 1'b1, 4'd3,  4'd4,  1'b0, 1, 0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 4'd14, 4'd15, 1'b0, 1, 0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 4'd15, 4'd15, 1'b1, 0, 0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 4'd15, 4'd0,  1'b0, 0, 1, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 4'd7,  4'd0,  1'b0, 0, 1, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 4'd0,  4'd1,  1'b0, 1, 0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 4'd15, 4'd15, 1'b1, 0, 0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 4'd15, 4'd15, 1'b1, 0, 0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 4'd9,  4'd10, 1'b1, 1, 0, 1'b1};
    vecs[9] = '{1'b0, 1'b1, 4'd15, 4'd15, 1'b1, 0, 0, 1'b0};

    bus.level_req_i   = 1'b0;
    bus.restart_req_i = 1'b0;
    tb_load = 1'b1;
    tb_val  = 4'd0;
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_upcount", bus.upcount_InLow_o, 1);
    chk("rst_clear",   bus.clear_InLow_o, 1);
    chk("rst_busy",    bus.busy_o, 0);
    chk("rst_ack",     bus.ack_o, 0);
    chk("rst_trans",   bus.transition_active_o, 0);
    chk("rst_max",     bus.max_level_o, 0);
    tb_load = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      preload(vecs[i].cnt0);
      u0 = n_up; c0 = n_clr; t0 = n_ta;
      bus.restart_req_i = vecs[i].rs;
      bus.level_req_i   = vecs[i].lv;
      wait_ack(k);
      nm = $sformatf("v%0d_latency", i);
      chk(nm, k, vecs[i].strobe ? 2 + EX : 0);
      chk($sformatf("v%0d_count", i), int'(cnt_m), int'(vecs[i].cnt1));
      chk($sformatf("v%0d_max", i), bus.max_level_o, vecs[i].maxl);
      @(negedge clk);
      bus.restart_req_i = 1'b0;
      bus.level_req_i   = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ack_width", i), bus.ack_o, 0);
      chk($sformatf("v%0d_busy_after", i), bus.busy_o, 0);
      chk($sformatf("v%0d_up_strobes", i), n_up - u0, vecs[i].ups);
      chk($sformatf("v%0d_clr_strobes", i), n_clr - c0, vecs[i].clrs);
      chk($sformatf("v%0d_trans_cycles", i), n_ta - t0, vecs[i].strobe ? EX : 0);
      repeat (2) @(negedge clk);
    end

    // Asynchronous reset while the sequencer is mid-transaction (HOLD when present).
    preload(4'd3);
    tick_en = 1'b0;
    bus.level_req_i = 1'b1;
    k = -1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if ((EX > 0) ? bus.transition_active_o : bus.busy_o) begin
        k = i;
        break;
      end
    end
    chk("midrst_reached", int'(k >= 0), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_upcount", bus.upcount_InLow_o, 1);
    chk("midrst_clear",   bus.clear_InLow_o, 1);
    chk("midrst_busy",    bus.busy_o, 0);
    chk("midrst_ack",     bus.ack_o, 0);
    chk("midrst_trans",   bus.transition_active_o, 0);
    chk("midrst_max",     bus.max_level_o, 0);
    bus.level_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_count", int'(cnt_m), (EX > 0) ? 4 : 3);
    chk("midrst_idle",  bus.busy_o, 0);

    // Simultaneous requests: restart first, then the still-held level request.
    preload(4'd5);
    u0 = n_up; c0 = n_clr;
    bus.restart_req_i = 1'b1;
    bus.level_req_i   = 1'b1;
    wait_ack(k);
    chk("both_first_latency", k, 2 + EX);
    chk("both_first_count",   int'(cnt_m), 0);
    chk("both_first_clr",     n_clr - c0, 1);
    chk("both_first_up",      n_up - u0, 0);
    @(negedge clk);
    bus.restart_req_i = 1'b0;
    wait_ack(k2);
    chk("both_second_seen",   int'(k2 >= 0), 1);
    chk("both_second_count",  int'(cnt_m), 1);
    chk("both_second_up",     n_up - u0, 1);
    chk("both_second_clr",    n_clr - c0, 1);
    @(negedge clk);
    bus.level_req_i = 1'b0;
    repeat (2) @(negedge clk);

    // Held request is served once; a one-cycle drop re-arms it.
    preload(4'd2);
    u0 = n_up; a0 = n_ack;
    bus.level_req_i = 1'b1;
    wait_ack(k);
    chk("held_first_latency", k, 2 + EX);
    repeat (20) @(posedge clk);
    #1;
    chk("held_no_restrobe", n_up - u0, 1);
    chk("held_no_reack",    n_ack - a0, 1);
    chk("held_idle",        bus.busy_o, 0);
    @(negedge clk);
    bus.level_req_i = 1'b0;
    @(negedge clk);
    bus.level_req_i = 1'b1;
    wait_ack(k);
    chk("held_second_latency", k, 2 + EX);
    chk("held_second_up",      n_up - u0, 2);
    chk("held_second_count",   int'(cnt_m), 4);
    @(negedge clk);
    bus.level_req_i = 1'b0;
    repeat (3) @(negedge clk);

    chk("strobes_never_both", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/transition_counter_ctrl.md
Name: transition_counter_ctrl

Overview:
Sequencer/arbiter in front of the 4-bit up-transition (level) counter of the Frogger core. It takes level-complete and restart requests from game logic and turns them into single-cycle active-low upcount/clear strobes for the counter. It holds a frame-tick-timed transition window and flags when the maximum level is reached. Sits between the game FSM and the counter; its strobe outputs wire directly to the counter's upcount_InLow/clear_InLow inputs.

Parameters:
LEVEL_MAX, 15, counter value at which further level-ups are refused (max 15, 4-bit)
HOLD_TICKS, 4, number of tick_i pulses spent in the transition window; 0 = skip window

Ports:
SC_upTRANSITIONCOUNTER_CLOCK_50  in  1  system clock, 50 MHz, rising edge
SC_upTRANSITIONCOUNTER_RESET_InHigh  in  1  reset, asynchronous, active-high
level_req_i  in  1  level-complete request, level-sensitive, held until ack_o
restart_req_i  in  1  game restart request, level-sensitive, held until ack_o
tick_i  in  1  frame tick, one-cycle pulse
count_i  in  4  readback of counter data bus
upcount_InLow_o  out  1  counter increment strobe, active-low
clear_InLow_o  out  1  counter clear strobe, active-low
busy_o  out  1  high whenever state != IDLE
ack_o  out  1  one-cycle completion pulse
transition_active_o  out  1  high during HOLD
max_level_o  out  1  sticky: level-up refused at LEVEL_MAX

Behaviour:
- Reset (async, any state): state=IDLE; upcount_InLow_o=1, clear_InLow_o=1, busy_o=0, ack_o=0, transition_active_o=0, max_level_o=0, hold counter=0, both arm flags=1.
- All outputs are Moore (decoded from registered state/flags); no combinational input-to-output paths.
- States: IDLE, CLEAR, UP, SETTLE, HOLD, ACK.
- IDLE: arbitration on armed requests; restart has fixed priority over level.
  - restart_req_i & arm_r -> CLEAR.
  - else level_req_i & arm_l & count_i==LEVEL_MAX -> max_level_o<=1, ACK (no strobe, no wrap).
  - else level_req_i & arm_l -> UP.
- CLEAR: clear_InLow_o=0 for exactly one cycle; max_level_o<=0 -> SETTLE.
- UP: upcount_InLow_o=0 for exactly one cycle -> SETTLE.
- SETTLE: one cycle; count_i now reflects the update -> HOLD if HOLD_TICKS>0, else ACK. Hold counter loaded 0.
- HOLD: transition_active_o=1; hold counter increments on tick_i; when counter==HOLD_TICKS-1 and tick_i -> ACK.
- ACK: ack_o=1 one cycle; serviced requester's arm flag cleared -> IDLE.
- Arm flags: arm_x set again only after its request is sampled low for >=1 cycle. A request still high after ack is not re-served.
- No preemption: a request raised while busy is served on return to IDLE, restart still first.
- Latency: request sampled in IDLE at edge N -> strobe during cycle N+1 -> ack at cycle N+3 (HOLD_TICKS=0 or feature off). With hold: N+3+time-to-HOLD_TICKS ticks.
- tick_i outside HOLD is ignored. Both strobes are never low in the same cycle.

Optional Feature:
TRANSITION_HOLD_EN
- Defined: HOLD state and hold counter present, as above.
- Undefined: HOLD removed; SETTLE -> ACK always; transition_active_o tied 0; tick_i unused; HOLD_TICKS ignored.

Decomposition:
- Shared package tcc_pkg: state enum encoding (3 bits; IDLE=0, CLEAR=1, UP=2, SETTLE=3, HOLD=4, ACK=5), COUNT_W=4, default LEVEL_MAX.
- One natural sub-module: tcc_hold_timer (tick counter with load/done), instantiated only under TRANSITION_HOLD_EN.

Test Plan:
- Reset mid-HOLD: assert reset during HOLD -> all outputs at reset values the same cycle; strobes high; max_level_o=0.
- Level-up, HOLD_TICKS=4, count_i=3: level_req_i=1 -> one upcount_InLow_o low cycle; transition_active_o until 4th tick; ack_o one cycle; with counter attached, count reads 4.
- Simultaneous level_req_i and restart_req_i in IDLE -> CLEAR served first, ack; then UP served once restart is low and re-armed; counter ends at 1.
- Max level: count_i=15, level_req_i -> no upcount strobe, max_level_o=1, ack at N+1; then restart -> clear strobe, max_level_o=0, count 0.
- Held request: level_req_i kept high 20 cycles after ack -> no second strobe; drop 1 cycle, raise -> second strobe.
- Feature off (no TRANSITION_HOLD_EN): level request -> ack exactly 3 cycles after sampling edge; transition_active_o stays 0 with ticks toggling.
